alu_arbiter: RTL

Shares the single combinational ALU instance between two requesters: port 0 is the pipeline execute stage and port 1 is the multicycle helper unit. The block arbitrates once per cycle and drives the ALU inputs from the winning port. It captures the ALU outputs into a per-port response register and returns them over a valid/ready handshake. It also keeps saturating per-port grant counters for performance monitoring.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_rsp_slot.sv | 64 ++++++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Purpose: shared opcode/flag definitions for the ALU sharing arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_arbiter_pkg;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_AND = 5'b00010;
   localparam logic [4:0] OP_OR  = 5'b00011;
   localparam logic [4:0] OP_SLL = 5'b00100;
   localparam logic [4:0] OP_SRA = 5'b00101;

   // Bit positions inside the 4-bit response flags word.
   localparam int FLAG_ERR = 3;
   localparam int FLAG_OVF = 2;
   localparam int FLAG_LT  = 1;
   localparam int FLAG_NE  = 0;

   function automatic logic op_legal(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_SLL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// Purpose: one-deep response register plus saturating grant counter for one port.
// Latency: response valid the cycle after accept.
// Backpressure: slot stays full until rsp_ready; the arbiter refuses new grants while full and not draining.
module alu_rsp_slot
   import alu_arbiter_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             accept,
   input  logic             rsp_ready,
   input  logic [4:0]       opcode,
   input  logic [31:0]      alu_result,
   input  logic             alu_overflow,
   input  logic             alu_isLessThan,
   input  logic             alu_isNotEqual,
   output logic             rsp_valid,
   output logic [31:0]      result,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] gnt_cnt
);

   logic        legal;
   logic [31:0] cap_result;
   logic [3:0]  cap_flags;

   assign legal = op_legal(opcode);

   // Illegal opcodes return a zero result with only the error flag set.
   always_comb begin
      cap_flags  = 4'b0000;
      cap_result = 32'd0;
      if (legal) begin
         cap_result         = alu_result;
         cap_flags[FLAG_OVF] = alu_overflow;
         cap_flags[FLAG_LT]  = alu_isLessThan;
         cap_flags[FLAG_NE]  = alu_isNotEqual;
      end else begin
         cap_flags[FLAG_ERR] = 1'b1;
      end
   end

   // Load on accept (new data beats a same-cycle drain), otherwise clear on drain.
   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         result    <= 32'd0;
         flags     <= 4'b0000;
         gnt_cnt   <= '0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         result    <= cap_result;
         flags     <= cap_flags;
         if (gnt_cnt != {CNT_W{1'b1}}) begin
            gnt_cnt <= gnt_cnt + 1'b1;
         end
      end else if (rsp_ready && rsp_valid) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: shares one combinational ALU between execute stage (port 0) and helper unit (port 1).
// Latency: grant is combinational; response valid one cycle after the grant.
// Backpressure: a port with a full, undrained response slot is not granted.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 16
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             rq0_valid,
   output logic             rq0_ready,
   input  logic [31:0]      rq0_opA,
   input  logic [31:0]      rq0_opB,
   input  logic [4:0]       rq0_opcode,
   input  logic [4:0]       rq0_shamt,
   input  logic             rq1_valid,
   output logic             rq1_ready,
   input  logic [31:0]      rq1_opA,
   input  logic [31:0]      rq1_opB,
   input  logic [4:0]       rq1_opcode,
   input  logic [4:0]       rq1_shamt,
   output logic             rs0_valid,
   input  logic             rs0_ready,
   output logic [31:0]      rs0_result,
   output logic [3:0]       rs0_flags,
   output logic             rs1_valid,
   input  logic             rs1_ready,
   output logic [31:0]      rs1_result,
   output logic [3:0]       rs1_flags,
   output logic [31:0]      alu_opA,
   output logic [31:0]      alu_opB,
   output logic [4:0]       alu_opcode,
   output logic [4:0]       alu_shamt,
   input  logic [31:0]      alu_result,
   input  logic             alu_isNotEqual,
   input  logic             alu_isLessThan,
   input  logic             alu_overflow,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   logic elig0, elig1;
   logic gnt0, gnt1;
   logic last1;   // 1 when port 1 won the most recent grant

   // A full slot that drains this cycle can take a new response.
   assign elig0 = rq0_valid && (!rs0_valid || rs0_ready);
   assign elig1 = rq1_valid && (!rs1_valid || rs1_ready);

   // Pick at most one winner; no grants are issued while reset is asserted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (elig0 && elig1) begin
            if ((FIXED_PRIO != 0) || last1) gnt0 = 1'b1;
            else                            gnt1 = 1'b1;
         end else begin
            gnt0 = elig0;
            gnt1 = elig1;
         end
      end
   end

   assign rq0_ready = gnt0;
   assign rq1_ready = gnt1;

   // Round-robin pointer moves only on a grant; reset makes port 0 win first.
   always_ff @(posedge clock) begin
      if (reset)     last1 <= 1'b1;
      else if (gnt0) last1 <= 1'b0;
      else if (gnt1) last1 <= 1'b1;
   end

   // Drive the shared ALU from the winner, zero when idle.
   always_comb begin
      alu_opA    = 32'd0;
      alu_opB    = 32'd0;
      alu_opcode = 5'd0;
      alu_shamt  = 5'd0;
      if (gnt0) begin
         alu_opA    = rq0_opA;
         alu_opB    = rq0_opB;
         alu_opcode = rq0_opcode;
         alu_shamt  = rq0_shamt;
      end else if (gnt1) begin
         alu_opA    = rq1_opA;
         alu_opB    = rq1_opB;
         alu_opcode = rq1_opcode;
         alu_shamt  = rq1_shamt;
      end
   end

   alu_rsp_slot #(.CNT_W(CNT_W)) u_slot0 (
      .clock          (clock),
      .reset          (reset),
      .accept         (gnt0),
      .rsp_ready      (rs0_ready),
      .opcode         (alu_opcode),
      .alu_result     (alu_result),
      .alu_overflow   (alu_overflow),
      .alu_isLessThan (alu_isLessThan),
      .alu_isNotEqual (alu_isNotEqual),
      .rsp_valid      (rs0_valid),
      .result         (rs0_result),
      .flags          (rs0_flags),
      .gnt_cnt        (gnt_cnt0)
   );

   alu_rsp_slot #(.CNT_W(CNT_W)) u_slot1 (
      .clock          (clock),
      .reset          (reset),
      .accept         (gnt1),
      .rsp_ready      (rs1_ready),
      .opcode         (alu_opcode),
      .alu_result     (alu_result),
      .alu_overflow   (alu_overflow),
      .alu_isLessThan (alu_isLessThan),
      .alu_isNotEqual (alu_isNotEqual),
      .rsp_valid      (rs1_valid),
      .result         (rs1_result),
      .flags          (rs1_flags),
      .gnt_cnt        (gnt_cnt1)
   );

endmodule
